// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Address/data widths, strobes and owner-state encoding.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  wstrb_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_M0,
    RD_M1
  } arb_state_e;

  localparam int unsigned ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant selection: M1 by default, M0 when boosted.
// Pure combinational so it can be reused for more masters.
module mem_arb_prio (
  input  logic i_en,
  input  logic i_boost,
  input  logic i_m0_req,
  input  logic i_m1_req,
  output logic o_m0_gnt,
  output logic o_m1_gnt
);

  always_comb begin
    o_m0_gnt = 1'b0;
    o_m1_gnt = 1'b0;
    priority case (1'b1)
      !i_en:                o_m0_gnt = 1'b0;
      i_boost && i_m0_req:  o_m0_gnt = 1'b1;
      i_m1_req:             o_m1_gnt = 1'b1;
      i_m0_req:             o_m0_gnt = 1'b1;
      default:              o_m0_gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter for the unified memory port.
// Optional perf counters: define ARB_PERF_CNT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req_i,
  input  addr_t            m0_addr_i,
  output logic             m0_gnt_o,
  output logic             m0_rvalid_o,
  output data_t            m0_rdata_o,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  addr_t            m1_addr_i,
  input  wstrb_t           m1_wstrb_i,
  input  data_t            m1_wdata_i,
  output logic             m1_gnt_o,
  output logic             m1_rvalid_o,
  output data_t            m1_rdata_o,
  output addr_t            mem_addr_o,
  output logic             mem_ren_o,
  output logic             mem_wen_o,
  output wstrb_t           mem_wstrb_o,
  output data_t            mem_wdata_o,
  input  data_t            mem_rdata_i,
  output logic [CNT_W-1:0] perf_m0_gnt_o,
  output logic [CNT_W-1:0] perf_m1_gnt_o,
  output logic [CNT_W-1:0] perf_m0_stall_o
);

  // Keep the counter at least 1 bit wide when boosting is disabled.
  localparam int unsigned SW =
    (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  arb_state_e    r_state;
  logic [SW-1:0] r_starve;
  logic          w_boost;
  logic          w_g0;
  logic          w_g1;
  logic          w_m1_rd;
  logic          w_m0_stall;

  assign w_boost = (STARVE_LIMIT != 0) && (r_starve == LIM);

  mem_arb_prio u_prio (
    .i_en     (rst_n),
    .i_boost  (w_boost),
    .i_m0_req (m0_req_i),
    .i_m1_req (m1_req_i),
    .o_m0_gnt (w_g0),
    .o_m1_gnt (w_g1)
  );

  assign m0_gnt_o   = w_g0;
  assign m1_gnt_o   = w_g1;
  assign w_m1_rd    = w_g1 && !m1_we_i;
  assign w_m0_stall = m0_req_i && !w_g0;

  always_comb begin
    mem_addr_o  = '0;
    mem_wstrb_o = '0;
    mem_wdata_o = '0;
    if (w_g0) begin
      mem_addr_o  = m0_addr_i;
    end else if (w_g1) begin
      mem_addr_o  = m1_addr_i;
      mem_wstrb_o = m1_wstrb_i;
      mem_wdata_o = m1_wdata_i;
    end
  end

  assign mem_ren_o = w_g0 || w_m1_rd;
  assign mem_wen_o = w_g1 && m1_we_i;

  // Owner of the read whose data arrives next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      if (w_g0)
        r_state <= RD_M0;
      else if (w_m1_rd)
        r_state <= RD_M1;
      else
        r_state <= IDLE;
      if (w_m0_stall) begin
        if (r_starve != LIM)
          r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign m0_rvalid_o = (r_state == RD_M0);
  assign m1_rvalid_o = (r_state == RD_M1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_m0g;
  logic [CNT_W-1:0] r_perf_m1g;
  logic [CNT_W-1:0] r_perf_m0s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_m0g <= '0;
      r_perf_m1g <= '0;
      r_perf_m0s <= '0;
    end else begin
      if (w_g0)
        r_perf_m0g <= r_perf_m0g + 1'b1;
      if (w_g1)
        r_perf_m1g <= r_perf_m1g + 1'b1;
      if (w_m0_stall)
        r_perf_m0s <= r_perf_m0s + 1'b1;
    end
  end

  assign perf_m0_gnt_o   = r_perf_m0g;
  assign perf_m1_gnt_o   = r_perf_m1g;
  assign perf_m0_stall_o = r_perf_m0s;
`else
  assign perf_m0_gnt_o   = '0;
  assign perf_m1_gnt_o   = '0;
  assign perf_m0_stall_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a word memory model.
// Perf checks follow ARB_PERF_CNT_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0;
  logic [31:0] m0_addr = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] p_m0g, p_m1g, p_m0s;

  int checks = 0;
  int failures = 0;
  int e_m0g = 0, e_m1g = 0, e_m0s = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we),
    .m1_addr_i(m1_addr), .m1_wstrb_i(m1_wstrb),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_ren_o(mem_ren),
    .mem_wen_o(mem_wen), .mem_wstrb_o(mem_wstrb),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .perf_m0_gnt_o(p_m0g), .perf_m1_gnt_o(p_m1g),
    .perf_m0_stall_o(p_m0s)
  );

  always @(posedge clk) begin
    if (mem_ren)
      mem_rdata <= mem[mem_addr[5:2]];
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b])
          mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        g0, g1, ren, wen;
    logic [31:0] maddr;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic a_m0, input logic [31:0] a_a0,
    input logic a_m1, input logic a_we, input logic [31:0] a_a1,
    input logic [3:0] a_st, input logic [31:0] a_wd,
    input logic e_g0, input logic e_g1, input logic e_ren,
    input logic e_wen, input logic [31:0] e_ad,
    input logic e_rv0, input logic e_rv1,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1);
    vec_t v;
    v.m0_req = a_m0; v.m0_addr = a_a0; v.m1_req = a_m1;
    v.m1_we = a_we; v.m1_addr = a_a1; v.wstrb = a_st;
    v.wdata = a_wd; v.g0 = e_g0; v.g1 = e_g1; v.ren = e_ren;
    v.wen = e_wen; v.maddr = e_ad; v.rv0 = e_rv0;
    v.rv1 = e_rv1; v.rd0 = e_rd0; v.rd1 = e_rd1;
    return v;
  endfunction

  // Drive one cycle, check outputs mid-cycle, advance to next edge.
  task automatic apply(input vec_t v, input string tag);
    m0_req = v.m0_req; m0_addr = v.m0_addr;
    m1_req = v.m1_req; m1_we = v.m1_we; m1_addr = v.m1_addr;
    m1_wstrb = v.wstrb; m1_wdata = v.wdata;
    #1;
    chk({tag, " m0_gnt"}, 32'(m0_gnt), 32'(v.g0));
    chk({tag, " m1_gnt"}, 32'(m1_gnt), 32'(v.g1));
    chk({tag, " one_gnt"}, 32'(m0_gnt && m1_gnt), 32'd0);
    chk({tag, " ren"}, 32'(mem_ren), 32'(v.ren));
    chk({tag, " wen"}, 32'(mem_wen), 32'(v.wen));
    chk({tag, " addr"}, mem_addr, v.maddr);
    chk({tag, " wstrb"}, 32'(mem_wstrb),
        v.g1 ? 32'(v.wstrb) : 32'd0);
    chk({tag, " wdata"}, mem_wdata, v.g1 ? v.wdata : 32'd0);
    chk({tag, " rv0"}, 32'(m0_rvalid), 32'(v.rv0));
    chk({tag, " rv1"}, 32'(m1_rvalid), 32'(v.rv1));
    chk({tag, " rd0"}, m0_rdata, v.rd0);
    chk({tag, " rd1"}, m1_rdata, v.rd1);
    if (v.g0) e_m0g++;
    if (v.g1) e_m1g++;
    if (v.m0_req && !v.g0) e_m0s++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string tag);
`ifdef ARB_PERF_CNT_EN
    chk({tag, " perf_m0g"}, p_m0g, 32'(e_m0g));
    chk({tag, " perf_m1g"}, p_m1g, 32'(e_m1g));
    chk({tag, " perf_m0s"}, p_m0s, 32'(e_m0s));
`else
    chk({tag, " perf_m0g"}, p_m0g, 32'd0);
    chk({tag, " perf_m1g"}, p_m1g, 32'd0);
    chk({tag, " perf_m0s"}, p_m0s, 32'd0);
`endif
  endtask

  vec_t tbl[9];
  vec_t sv;

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = 32'h1000_0000 + 32'(i);

    tbl[0] = mk(0,0, 0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,0);
    tbl[1] = mk(1,32'h10, 0,0,0, 0,0, 1,0,1,0, 32'h10, 0,0, 0,0);
    tbl[2] = mk(0,0, 0,0,0, 0,0, 0,0,0,0, 0,
                1,0, 32'h1000_0004,0);
    tbl[3] = mk(0,0, 1,1,32'h20, 4'b0011,32'hDEAD_BEEF,
                0,1,0,1, 32'h20, 0,0, 0,0);
    tbl[4] = mk(0,0, 1,0,32'h20, 0,0, 0,1,1,0, 32'h20, 0,0, 0,0);
    tbl[5] = mk(1,32'h14, 0,0,0, 0,0, 1,0,1,0, 32'h14,
                0,1, 0,32'h1000_BEEF);
    tbl[6] = mk(0,0, 1,0,32'h18, 0,0, 0,1,1,0, 32'h18,
                1,0, 32'h1000_0005,0);
    tbl[7] = mk(1,32'h1C, 0,0,0, 0,0, 1,0,1,0, 32'h1C,
                0,1, 0,32'h1000_0006);
    tbl[8] = mk(0,0, 0,0,0, 0,0, 0,0,0,0, 0,
                1,0, 32'h1000_0007,0);

    // Reset state with requests pending.
    m0_req = 1'b1; m1_req = 1'b1;
    #2;
    chk("rst m0_gnt", 32'(m0_gnt), 0);
    chk("rst m1_gnt", 32'(m1_gnt), 0);
    chk("rst ren", 32'(mem_ren), 0);
    chk("rst rv0", 32'(m0_rvalid), 0);
    chk("rst rv1", 32'(m1_rvalid), 0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Starvation: both masters read-request continuously.
    for (int k = 0; k < 13; k++) begin
      logic both, g0, rv0, rv1;
      both = (k != 6);
      g0   = (k == 4) || (k == 11);
      rv0  = (k == 5) || (k == 12);
      rv1  = (k >= 1) && !rv0;
      if (k == 12) both = 1'b0;
      sv = mk(both, 32'h00, k != 12, 0, 32'h04, 0, 0,
              g0, !g0 && k != 12, k != 12, 0,
              g0 ? 32'h00 : (k == 12 ? 32'h0 : 32'h04),
              rv0, rv1,
              rv0 ? 32'h1000_0000 : 32'h0,
              rv1 ? 32'h1000_0001 : 32'h0);
      apply(sv, $sformatf("starve%0d", k));
    end
    chk_perf("perf");

    // Reset asserted before the response of an M1 read.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h08;
    #1;
    chk("rr gnt", 32'(m1_gnt), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr gnt_in_rst", 32'(m1_gnt), 0);
    chk("rr ren_in_rst", 32'(mem_ren), 0);
    @(posedge clk);
    #1;
    chk("rr rv1", 32'(m1_rvalid), 0);
    chk("rr rd1", m1_rdata, 0);
    m1_req = 1'b0; m1_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    e_m0g = 0; e_m1g = 0; e_m0s = 0;
    @(posedge clk);
    #1;
    chk("rr post rv0", 32'(m0_rvalid), 0);
    chk("rr post rv1", 32'(m1_rvalid), 0);
    chk("rr post addr", mem_addr, 0);
    chk_perf("rr post");
    apply(mk(1,32'h08, 0,0,0, 0,0, 1,0,1,0, 32'h08, 0,0, 0,0),
          "rr r0");
    apply(mk(0,0, 0,0,0, 0,0, 0,0,0,0, 0,
             1,0, 32'h1000_0002,0), "rr r1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
